// File: rtl/imm_decode_queue.sv
// ---------------------------------------------------------------------------
// imm_decode_queue
//
// Decode-stage front end. Takes 32-bit RV32 instruction words from fetch over
// a valid/ready handshake, classifies the immediate format from the opcode,
// builds the 32-bit immediate and stores {instr, fmt, imm} in a small FIFO
// that the execute-side consumer drains over its own valid/ready handshake.
// Also counts (with saturation) how many ILLEGAL instructions were accepted.
//
// Parameters
//   DEPTH  FIFO entries (power of 2, >= 2)
//   CNT_W  width of the saturating illegal-instruction counter
//
// Ports
//   clk          clock, all state changes on the rising edge
//   rst          asynchronous active-high reset
//   flush        synchronous queue clear (branch redirect)
//   in_valid     fetch presents in_instr
//   in_ready     queue has room (low while rst is high)
//   in_instr     instruction word from fetch
//   out_valid    head entry is valid
//   out_ready    consumer takes the head entry
//   out_instr    head instruction word
//   out_fmt      head format: 0 R/none, 1 I, 2 S, 3 B, 4 U, 5 J, 6 CSR-zimm, 7 ILLEGAL
//   out_imm      head immediate
//   illegal_cnt  number of accepted ILLEGAL instructions (saturating)
//
// Build option
//   IMM_SIGN_EXT_EN  when defined, I/S/B/J immediates are sign-extended from
//                    instr[31]; otherwise they are zero-extended. U, CSR-zimm
//                    and I-shift immediates are the same in both builds.
// ---------------------------------------------------------------------------
module imm_decode_queue #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [2:0]       out_fmt,
  output logic [31:0]      out_imm,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_QW = PTR_W + 1;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_CSR = 3'd6,
    FMT_ILL = 3'd7
  } fmt_e;

  logic [31:0]       mem_instr [DEPTH];
  logic [2:0]        mem_fmt   [DEPTH];
  logic [31:0]       mem_imm   [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_QW-1:0] count;

  fmt_e              dec_fmt;
  logic [31:0]       dec_imm;
  logic              fill;
  logic              push;
  logic              pop;
  logic              full;

`ifdef IMM_SIGN_EXT_EN
  assign fill = in_instr[31];
`else
  assign fill = 1'b0;
`endif

  // in_ready looks only at the registered occupancy (plus reset), so there is
  // never a combinational path from out_ready back to fetch. A full queue
  // therefore refuses a new word even in a cycle where the head is popped.
  assign full      = (count == CNT_QW'(DEPTH));
  assign in_ready  = !rst && !full;
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_instr = mem_instr[rd_ptr];
  assign out_fmt   = mem_fmt[rd_ptr];
  assign out_imm   = mem_imm[rd_ptr];

  // Combinational decode of the incoming word. The opcode picks the format,
  // and the format picks how the immediate bits are gathered. Shift-immediate
  // ALU ops (funct3[1:0]=01) carry only a 5-bit unsigned shamt, and SYSTEM
  // ops with funct3[2]=1 carry a 5-bit unsigned zimm in the rs1 field; every
  // other SYSTEM op (ECALL/EBREAK, register CSR ops) has no immediate.
  always_comb begin
    dec_fmt = FMT_ILL;
    dec_imm = '0;
    case (in_instr[6:0])
      7'b0110011, 7'b0001111: begin
        dec_fmt = FMT_R;
      end
      7'b0010011: begin
        dec_fmt = FMT_I;
        if (in_instr[13:12] == 2'b01)
          dec_imm = {27'b0, in_instr[24:20]};
        else
          dec_imm = {{20{fill}}, in_instr[31:20]};
      end
      7'b0000011, 7'b1100111: begin
        dec_fmt = FMT_I;
        dec_imm = {{20{fill}}, in_instr[31:20]};
      end
      7'b0100011: begin
        dec_fmt = FMT_S;
        dec_imm = {{20{fill}}, in_instr[31:25], in_instr[11:7]};
      end
      7'b1100011: begin
        dec_fmt = FMT_B;
        dec_imm = {{19{fill}}, in_instr[31], in_instr[7], in_instr[30:25],
                   in_instr[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec_fmt = FMT_U;
        dec_imm = {in_instr[31:12], 12'b0};
      end
      7'b1101111: begin
        dec_fmt = FMT_J;
        dec_imm = {{11{fill}}, in_instr[31], in_instr[19:12], in_instr[20],
                   in_instr[30:21], 1'b0};
      end
      7'b1110011: begin
        if (in_instr[14]) begin
          dec_fmt = FMT_CSR;
          dec_imm = {27'b0, in_instr[19:15]};
        end else begin
          dec_fmt = FMT_R;
        end
      end
      default: begin
        dec_fmt = FMT_ILL;
        dec_imm = '0;
      end
    endcase
  end

  // Pointer and occupancy bookkeeping. Flush empties the queue by pulling the
  // write pointer back onto the read pointer rather than zeroing both, so the
  // head slot is untouched and the head outputs keep showing their last value.
  // Any push or pop in the flush cycle is dropped. Pointers wrap naturally
  // because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= rd_ptr;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_QW'(1);
        2'b01:   count <= count - CNT_QW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage. Cleared on reset so the head outputs read as zero out of
  // reset; written only by a real (non-flushed) push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_instr[i] <= '0;
        mem_fmt[i]   <= '0;
        mem_imm[i]   <= '0;
      end
    end else if (push && !flush) begin
      mem_instr[wr_ptr] <= in_instr;
      mem_fmt[wr_ptr]   <= dec_fmt;
      mem_imm[wr_ptr]   <= dec_imm;
    end
  end

  // Illegal-instruction counter: one step per accepted ILLEGAL word, sticking
  // at all-ones. Only reset clears it; a flush leaves it alone, and a word
  // pushed during a flush was never accepted so it is not counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_cnt <= '0;
    end else if (push && !flush && (dec_fmt == FMT_ILL) && (illegal_cnt != '1)) begin
      illegal_cnt <= illegal_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_imm_decode_queue.sv
// ---------------------------------------------------------------------------
// tb_imm_decode_queue
//
// Self-checking bench for imm_decode_queue. A table of known instruction
// words with hand-derived formats and immediates is streamed through the
// queue, a few hand-written sequences cover back-pressure, flush, reset and
// streaming, and a randomized phase compares the DUT against a queue-based
// reference model that decodes immediates with plain shift/mask arithmetic.
// Honors IMM_SIGN_EXT_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_imm_decode_queue;

  localparam int DEPTH = 2;
  localparam int CNT_W = 16;

`ifdef IMM_SIGN_EXT_EN
  localparam bit SIGN_EXT = 1'b1;
`else
  localparam bit SIGN_EXT = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic [2:0]       out_fmt;
  logic [31:0]      out_imm;
  logic [CNT_W-1:0] illegal_cnt;

  imm_decode_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_fmt     (out_fmt),
    .out_imm     (out_imm),
    .illegal_cnt (illegal_cnt)
  );

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  fmt;
    logic [31:0] imm_zx;
    logic [31:0] imm_sx;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  fmt;
    logic [31:0] imm;
  } entry_t;

  int num_checks = 0;
  int num_fails  = 0;

  // Free-running clock: rising edges at 5, 15, 25, ... so the bench drives
  // and samples on the falling edge, well away from the active edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run always ends even if something wedges.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison: counts it, and reports a failing one on a single line.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    num_checks++;
    if (act !== exp) begin
      num_fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive every DUT input for the coming rising edge.
  task automatic applyStimulus(input logic v, input logic [31:0] w,
                               input logic rdy, input logic fl);
    in_valid  = v;
    in_instr  = w;
    out_ready = rdy;
    flush     = fl;
  endtask

  // Reference decode built from the ISA field layout with shifts and masks;
  // extension is done arithmetically by subtracting 2^n when the top bit of
  // the n-bit raw immediate is set.
  function automatic void refDecode(input logic [31:0] w, output logic [2:0] f,
                                    output logic [31:0] imm);
    logic [31:0] raw;
    int nbits;
    int op;
    int f3;
    op    = int'(w[6:0]);
    f3    = int'(w[14:12]);
    raw   = '0;
    nbits = 0;
    f     = 3'd7;
    imm   = '0;
    case (op)
      'h33, 'h0F: f = 3'd0;
      'h13: begin
        f = 3'd1;
        if (f3 % 4 == 1) imm = (w >> 20) & 32'd31;
        else begin raw = w >> 20; nbits = 12; end
      end
      'h03, 'h67: begin f = 3'd1; raw = w >> 20; nbits = 12; end
      'h23: begin
        f = 3'd2;
        raw = ((w >> 25) << 5) | ((w >> 7) & 32'd31);
        nbits = 12;
      end
      'h63: begin
        f = 3'd3;
        raw = ((w >> 31) << 12) | (((w >> 7) & 32'd1) << 11) |
              (((w >> 25) & 32'd63) << 5) | (((w >> 8) & 32'd15) << 1);
        nbits = 13;
      end
      'h37, 'h17: begin f = 3'd4; imm = w & 32'hFFFFF000; end
      'h6F: begin
        f = 3'd5;
        raw = ((w >> 31) << 20) | (((w >> 12) & 32'd255) << 12) |
              (((w >> 20) & 32'd1) << 11) | (((w >> 21) & 32'd1023) << 1);
        nbits = 21;
      end
      'h73: begin
        if (f3 >= 4) begin f = 3'd6; imm = (w >> 15) & 32'd31; end
        else f = 3'd0;
      end
      default: begin f = 3'd7; imm = '0; end
    endcase
    if (nbits > 0) begin
      imm = raw;
      if (SIGN_EXT && raw[nbits-1]) imm = raw - (32'd1 << nbits);
    end
  endfunction

  vec_t        vecs [17];
  entry_t      q [$];
  entry_t      e;
  logic [6:0]  ops [12];
  int          ill_exp;
  logic [31:0] wa, wb, wc, wd, ww, rnd;
  logic        rv, rr, rf;
  int          sel;
  int          nq;

  initial begin
    // Decode vectors: {instr, fmt, zero-extended imm, sign-extended imm}
    vecs[0]  = '{32'hFFF00093, 3'd1, 32'h00000FFF, 32'hFFFFFFFF};
    vecs[1]  = '{32'hFFDFF06F, 3'd5, 32'h001FFFFC, 32'hFFFFFFFC};
    vecs[2]  = '{32'h0000007F, 3'd7, 32'h00000000, 32'h00000000};
    vecs[3]  = '{32'h00105013, 3'd1, 32'h00000001, 32'h00000001};
    vecs[4]  = '{32'h00000033, 3'd0, 32'h00000000, 32'h00000000};
    vecs[5]  = '{32'hFE112C23, 3'd2, 32'h00000FF8, 32'hFFFFFFF8};
    vecs[6]  = '{32'h00000863, 3'd3, 32'h00000010, 32'h00000010};
    vecs[7]  = '{32'hFE000EE3, 3'd3, 32'h00001FFC, 32'hFFFFFFFC};
    vecs[8]  = '{32'h12345037, 3'd4, 32'h12345000, 32'h12345000};
    vecs[9]  = '{32'hABCDE017, 3'd4, 32'hABCDE000, 32'hABCDE000};
    vecs[10] = '{32'h300FD073, 3'd6, 32'h0000001F, 32'h0000001F};
    vecs[11] = '{32'h00000073, 3'd0, 32'h00000000, 32'h00000000};
    vecs[12] = '{32'h0000000F, 3'd0, 32'h00000000, 32'h00000000};
    vecs[13] = '{32'hFFC08067, 3'd1, 32'h00000FFC, 32'hFFFFFFFC};
    vecs[14] = '{32'h00412083, 3'd1, 32'h00000004, 32'h00000004};
    vecs[15] = '{32'h40F0D093, 3'd1, 32'h0000000F, 32'h0000000F};
    vecs[16] = '{32'h0000005B, 3'd7, 32'h00000000, 32'h00000000};

    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63,
            7'h37, 7'h17, 7'h6F, 7'h73, 7'h0F, 7'h7F};

    // Reset state, checked while reset is still held.
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    #2;
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset in_ready", 32'(in_ready), 32'd0);
    checkOutput("reset out_instr", out_instr, 32'd0);
    checkOutput("reset out_fmt", 32'(out_fmt), 32'd0);
    checkOutput("reset out_imm", out_imm, 32'd0);
    checkOutput("reset illegal_cnt", 32'(illegal_cnt), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("post-reset in_ready", 32'(in_ready), 32'd1);

    // Table phase: each word is pushed and appears at the head one edge later,
    // where it is popped by the same edge that pushes the next word.
    ill_exp = 0;
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1'b1, vecs[i].instr, 1'b1, 1'b0);
      @(negedge clk);
      if (vecs[i].fmt == 3'd7) ill_exp++;
      checkOutput($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'd1);
      checkOutput($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'd1);
      checkOutput($sformatf("vec%0d out_instr", i), out_instr, vecs[i].instr);
      checkOutput($sformatf("vec%0d out_fmt", i), 32'(out_fmt), 32'(vecs[i].fmt));
      checkOutput($sformatf("vec%0d out_imm", i), out_imm,
                  SIGN_EXT ? vecs[i].imm_sx : vecs[i].imm_zx);
      checkOutput($sformatf("vec%0d illegal_cnt", i), 32'(illegal_cnt), 32'(ill_exp));
    end
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("table drained out_valid", 32'(out_valid), 32'd0);

    // Back-pressure: A and B fill the queue, C stalls until space opens.
    wa = 32'h00100093; wb = 32'h00200113; wc = 32'h00300193;
    applyStimulus(1'b1, wa, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("bp in_ready after A", 32'(in_ready), 32'd1);
    checkOutput("bp head A", out_instr, wa);
    applyStimulus(1'b1, wb, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("bp in_ready after B", 32'(in_ready), 32'd0);
    applyStimulus(1'b1, wc, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("bp C stalled in_ready", 32'(in_ready), 32'd0);
    checkOutput("bp head still A", out_instr, wa);
    applyStimulus(1'b1, wc, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("bp head B", out_instr, wb);
    checkOutput("bp in_ready reopened", 32'(in_ready), 32'd1);
    applyStimulus(1'b1, wc, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("bp head C", out_instr, wc);
    checkOutput("bp C valid", 32'(out_valid), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("bp drained", 32'(out_valid), 32'd0);

    // Flush with a full queue and a word offered, then flush racing a real
    // push of an ILLEGAL word: nothing is kept and nothing is counted.
    wd = 32'hDEAD007F;
    applyStimulus(1'b1, wa, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, wb, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("flush pre full", 32'(in_ready), 32'd0);
    applyStimulus(1'b1, wd, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("flush full out_valid", 32'(out_valid), 32'd0);
    checkOutput("flush full in_ready", 32'(in_ready), 32'd1);
    checkOutput("flush head held", out_instr, wa);
    applyStimulus(1'b1, wa, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("flush refill head", out_instr, wa);
    applyStimulus(1'b1, wd, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("flush push out_valid", 32'(out_valid), 32'd0);
    checkOutput("flush push illegal_cnt", 32'(illegal_cnt), 32'(ill_exp));
    checkOutput("flush push head held", out_instr, wa);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("flush stays empty", 32'(out_valid), 32'd0);
    applyStimulus(1'b1, 32'h12345037, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("after flush head", out_instr, 32'h12345037);
    checkOutput("after flush fmt", 32'(out_fmt), 32'd4);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("after flush drained", 32'(out_valid), 32'd0);

    // Streaming: eight back-to-back words, one out per cycle, never stalled.
    for (int i = 0; i < 8; i++) begin
      ww = 32'h000000B7 | (32'(i + 1) << 12);
      applyStimulus(1'b1, ww, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput($sformatf("stream%0d in_ready", i), 32'(in_ready), 32'd1);
      checkOutput($sformatf("stream%0d out_valid", i), 32'(out_valid), 32'd1);
      checkOutput($sformatf("stream%0d out_instr", i), out_instr, ww);
      checkOutput($sformatf("stream%0d out_imm", i), out_imm, ww & 32'hFFFFF000);
    end
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("stream drained", 32'(out_valid), 32'd0);

    // Reset pulse with two entries queued clears everything at once.
    applyStimulus(1'b1, 32'h0000007F, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, 32'h00000013, 1'b0, 1'b0);
    @(negedge clk);
    ill_exp++;
    checkOutput("midrst pre out_valid", 32'(out_valid), 32'd1);
    checkOutput("midrst pre illegal_cnt", 32'(illegal_cnt), 32'(ill_exp));
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst illegal_cnt", 32'(illegal_cnt), 32'd0);
    checkOutput("midrst in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    checkOutput("midrst release in_ready", 32'(in_ready), 32'd1);
    checkOutput("midrst release out_instr", out_instr, 32'd0);

    // Randomized phase against the reference queue model.
    q.delete();
    ill_exp = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      nq = q.size();
      checkOutput("rnd out_valid", 32'(out_valid), 32'(nq != 0));
      checkOutput("rnd in_ready", 32'(in_ready), 32'(nq < DEPTH));
      checkOutput("rnd illegal_cnt", 32'(illegal_cnt), 32'(ill_exp));
      if (nq != 0) begin
        checkOutput("rnd out_instr", out_instr, q[0].instr);
        checkOutput("rnd out_fmt", 32'(out_fmt), 32'(q[0].fmt));
        checkOutput("rnd out_imm", out_imm, q[0].imm);
      end
      rnd = $urandom;
      sel = int'($urandom_range(0, 12));
      if (sel < 12) rnd[6:0] = ops[sel];
      rv = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 2) != 0);
      rf = ($urandom_range(0, 15) == 0);
      applyStimulus(rv, rnd, rr, rf);
      if (rf) begin
        q.delete();
      end else begin
        if (rv && nq < DEPTH) begin
          e.instr = rnd;
          refDecode(rnd, e.fmt, e.imm);
          if (e.fmt == 3'd7 && ill_exp < 65535) ill_exp++;
        end
        if (rr && nq > 0) void'(q.pop_front());
        if (rv && nq < DEPTH) q.push_back(e);
      end
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
